priv_sched: RTL and testbench
=============================

PRIV_SCHED -- requirements
Module: priv_sched

Interface
REQ-001 Parameter QUANTUM, default 8: user-mode instruction budget per time slice (1..15).
REQ-002 Parameter TRAP_VECTOR, default 4'h0: privileged entry address on any trap.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 step  input  1  CPU retired one instruction this cycle.
REQ-006 cur_addr  input  4  CPU virtual address of the next instruction to execute.
REQ-007 swap_req  input  1  CPU executed SWAP while privileged; requests return to user mode.
REQ-008 irq  input  4  level-sensitive external event lines.
REQ-009 irq_mask  input  4  1 = line enabled.
REQ-010 is_priv  output  1  CPU register-bank select; 1 = privileged bank.
REQ-011 redirect  output  1  one-cycle strobe; CPU loads redirect_addr as next address.
REQ-012 redirect_addr  output  4  target address for redirect.
REQ-013 saved_addr  output  4  user resume address captured at last trap.
REQ-014 cause  output  2  last trap cause: 00 none, 01 quantum expiry, 10 irq, 11 irq and expiry together.
REQ-015 irq_id  output  2  index of the lowest-numbered pending enabled irq at last trap.

Function
REQ-016 States SHALL be PRIV, TO_USER, USER, TO_PRIV; is_priv=1 in PRIV and TO_USER, 0 in USER and TO_PRIV.
REQ-017 PRIV: swap_req SHALL move to TO_USER on the next edge; all other inputs ignored.
REQ-018 TO_USER (one cycle): redirect=1, redirect_addr=saved_addr, quantum counter loaded with QUANTUM; next state USER.
REQ-019 USER: counter SHALL decrement by 1 on each cycle with step=1; no decrement when step=0.
REQ-020 USER: trap SHALL be taken when the counter reaches 0 after a decrement, or when (irq & irq_mask) != 0, whichever occurs first; evaluation is on the same edge as the step.
REQ-021 On the trap edge: saved_addr <= cur_addr, cause and irq_id updated, next state TO_PRIV.
REQ-022 TO_PRIV (one cycle): redirect=1, redirect_addr=TRAP_VECTOR; next state PRIV.
REQ-023 Simultaneous expiry and pending irq SHALL set cause=11 and a valid irq_id.
REQ-024 irq_id SHALL hold its previous value when cause=01.
REQ-025 swap_req in USER, TO_USER or TO_PRIV SHALL be ignored (SWAP is a no-op outside the privileged state).
REQ-026 irq pending in PRIV SHALL NOT trap; it is re-evaluated on the first USER cycle.
REQ-027 Counter arithmetic is 4-bit unsigned; decrement from 0 SHALL NOT occur (trap fires at 0).
REQ-028 redirect SHALL be 0 in PRIV and USER.

Reset
REQ-029 On reset: state=PRIV, is_priv=1, redirect=0, redirect_addr=0, saved_addr=0, cause=00, irq_id=0, counter=0.
REQ-030 Reset asserted mid-transition SHALL abandon it immediately; no redirect strobe after deassertion.
REQ-031 The first cycle after reset release SHALL be PRIV (boot in privileged mode).

Structure
REQ-032 State enum sched_state_t and cause encoding cause_t SHALL live in the shared types package with the CPU typedefs.
REQ-033 Quantum down-counter SHALL be a sub-module quantum_timer (load, dec, zero ports).
REQ-034 Outputs SHALL be registered or decoded from the state register only; no combinational input-to-output paths.

Verification
REQ-035 Reset, swap_req at cycle 3 -> redirect=1 in cycle 4 to addr 0, is_priv=0 from cycle 5.
REQ-036 USER with QUANTUM=8, step every cycle, cur_addr=4'h9 on the 8th step -> saved_addr=9, cause=01, redirect to TRAP_VECTOR.
REQ-037 USER, step held 0 for 20 cycles -> no trap; counter unchanged.
REQ-038 irq=4'b1010, irq_mask=4'b1000 in USER -> trap next edge, cause=10, irq_id=3.
REQ-039 irq pending and counter hitting 0 on the same edge -> cause=11.
REQ-040 reset pulsed during TO_USER -> PRIV, redirect=0, saved_addr=0.

Source files
------------

// File: rtl/priv_sched_pkg.sv
// rtl/priv_sched_pkg.sv - shared CPU and scheduler types for the privilege scheduler
package priv_sched_pkg;

   typedef logic [3:0] addr_t;
   typedef logic [3:0] irq_vec_t;
   typedef logic [1:0] irq_idx_t;

   typedef enum logic [1:0] {
      PRIV    = 2'd0,
      TO_USER = 2'd1,
      USER    = 2'd2,
      TO_PRIV = 2'd3
   } sched_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_QUANTUM = 2'b01,
      CAUSE_IRQ     = 2'b10,
      CAUSE_BOTH    = 2'b11
   } cause_t;

   localparam int QCNT_W = 4;

   // Lowest-numbered set bit wins; callers only use the result when some bit is set.
   function automatic irq_idx_t lowest_irq(input irq_vec_t v);
      irq_idx_t id;
      id = '0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) id = irq_idx_t'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/priv_sched_if.sv
// rtl/priv_sched_if.sv - CPU-facing bundle between the core and the privilege scheduler
interface priv_sched_if;
   import priv_sched_pkg::*;

   logic     step;
   addr_t    cur_addr;
   logic     swap_req;
   irq_vec_t irq;
   irq_vec_t irq_mask;
   logic     is_priv;
   logic     redirect;
   addr_t    redirect_addr;
   addr_t    saved_addr;
   logic [1:0] cause;
   irq_idx_t irq_id;

   modport master (
      output step, cur_addr, swap_req, irq, irq_mask,
      input  is_priv, redirect, redirect_addr, saved_addr, cause, irq_id
   );

   modport slave (
      input  step, cur_addr, swap_req, irq, irq_mask,
      output is_priv, redirect, redirect_addr, saved_addr, cause, irq_id
   );

endinterface

// File: rtl/priv_sched_quantum_timer.sv
// rtl/priv_sched_quantum_timer.sv - loadable down-counter that saturates at zero
module quantum_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/priv_sched.sv
// rtl/priv_sched.sv - time-slice scheduler switching the CPU between privileged and user banks
module priv_sched
   import priv_sched_pkg::*;
#(
   parameter int    QUANTUM     = 8,
   parameter addr_t TRAP_VECTOR = 4'h0
) (
   input  logic         clock,
   input  logic         reset,
   priv_sched_if.slave  bus
);

   sched_state_t         state;
   logic                 is_priv_q;
   logic                 redirect_q;
   addr_t                redirect_addr_q;
   addr_t                saved_addr_q;
   cause_t               cause_q;
   irq_idx_t             irq_id_q;

   logic [QCNT_W-1:0]    count;
   logic                 zero;
   logic                 load;
   logic                 dec;
   irq_vec_t             pending;
   logic                 expire;
   logic                 take_trap;

   assign pending   = bus.irq & bus.irq_mask;
   assign load      = (state == TO_USER);
   assign dec       = (state == USER) && bus.step;
   // Expiry is judged on the value the counter lands on this edge; a counter
   // already at zero in user mode is treated as expired rather than wrapping.
   assign expire    = (bus.step && (count == QCNT_W'(1))) || zero;
   assign take_trap = (state == USER) && (expire || (pending != '0));

   quantum_timer #(
      .WIDTH(QCNT_W)
   ) u_quantum_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_val (QCNT_W'(QUANTUM)),
      .dec      (dec),
      .count    (count),
      .zero     (zero)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= PRIV;
         is_priv_q       <= 1'b1;
         redirect_q      <= 1'b0;
         redirect_addr_q <= '0;
         saved_addr_q    <= '0;
         cause_q         <= CAUSE_NONE;
         irq_id_q        <= '0;
      end else begin
         unique case (state)
            PRIV: begin
               redirect_q      <= 1'b0;
               redirect_addr_q <= '0;
               is_priv_q       <= 1'b1;
               if (bus.swap_req) begin
                  state           <= TO_USER;
                  redirect_q      <= 1'b1;
                  redirect_addr_q <= saved_addr_q;
               end
            end
            TO_USER: begin
               state           <= USER;
               redirect_q      <= 1'b0;
               redirect_addr_q <= '0;
               is_priv_q       <= 1'b0;
            end
            USER: begin
               redirect_q      <= 1'b0;
               redirect_addr_q <= '0;
               is_priv_q       <= 1'b0;
               if (take_trap) begin
                  state           <= TO_PRIV;
                  redirect_q      <= 1'b1;
                  redirect_addr_q <= TRAP_VECTOR;
                  saved_addr_q    <= bus.cur_addr;
                  if (pending != '0) begin
                     cause_q  <= expire ? CAUSE_BOTH : CAUSE_IRQ;
                     irq_id_q <= lowest_irq(pending);
                  end else begin
                     cause_q  <= CAUSE_QUANTUM;
                  end
               end
            end
            TO_PRIV: begin
               state           <= PRIV;
               redirect_q      <= 1'b0;
               redirect_addr_q <= '0;
               is_priv_q       <= 1'b1;
            end
            default: begin
               state           <= PRIV;
               redirect_q      <= 1'b0;
               redirect_addr_q <= '0;
               is_priv_q       <= 1'b1;
            end
         endcase
      end
   end

   assign bus.is_priv       = is_priv_q;
   assign bus.redirect      = redirect_q;
   assign bus.redirect_addr = redirect_addr_q;
   assign bus.saved_addr    = saved_addr_q;
   assign bus.cause         = cause_q;
   assign bus.irq_id        = irq_id_q;

endmodule

// File: tb/tb_priv_sched.sv
// tb/tb_priv_sched.sv - scoreboard bench for priv_sched with a slice-level reference model
module tb_priv_sched;

   localparam int         Q  = 8;
   localparam logic [3:0] TV = 4'hC;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   priv_sched_if bus();

   priv_sched #(
      .QUANTUM     (Q),
      .TRAP_VECTOR (TV)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [3:0] addr;
      logic       priv;
      logic [3:0] saved;
      logic [1:0] cause;
      logic [1:0] id;
   } exp_t;

   exp_t q[$];

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: what the scheduler has recorded and how much budget the slice has left.
   logic [3:0] m_saved;
   logic [1:0] m_cause;
   logic [1:0] m_id;
   int         m_budget;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] lowest(input logic [3:0] p);
      int k = 0;
      while (k < 3 && !p[k]) k++;
      return 2'(k);
   endfunction

   task automatic push(input logic [3:0] a, input logic p);
      exp_t e;
      chk("previous_redirect_seen", 8'(q.size()), 8'd0);
      q.delete();
      e = '{a, p, m_saved, m_cause, m_id};
      q.push_back(e);
   endtask

   always @(negedge clock) begin
      if (!reset && bus.redirect !== 1'b0) begin
         if (q.size() == 0) begin
            chk("unexpected_redirect", {7'd0, bus.redirect}, 8'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("redirect_addr", 8'(bus.redirect_addr), 8'(e.addr));
            chk("redirect_is_priv", 8'(bus.is_priv), 8'(e.priv));
            chk("saved_addr", 8'(bus.saved_addr), 8'(e.saved));
            chk("cause", 8'(bus.cause), 8'(e.cause));
            chk("irq_id", 8'(bus.irq_id), 8'(e.id));
         end
      end
   end

   task automatic apply(input logic sw, input logic st, input logic [3:0] addr,
                        input logic [3:0] ir, input logic [3:0] mk);
      bus.swap_req = sw;
      bus.step     = st;
      bus.cur_addr = addr;
      bus.irq      = ir;
      bus.irq_mask = mk;
      @(posedge clock);
      #1;
   endtask

   task automatic noise();
      apply(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic priv_idle(input int n);
      repeat (n) apply(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic enter_user();
      push(m_saved, 1'b1);
      apply(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      noise();
      m_budget = Q;
   endtask

   task automatic user_cycle(input logic st, input logic [3:0] addr, input logic [3:0] ir,
                             input logic [3:0] mk, output bit trapped);
      logic [3:0] p;
      int         left;
      bit         expired;
      p       = ir & mk;
      left    = m_budget - int'(st);
      expired = (left == 0);
      trapped = expired || (p != 4'd0);
      if (trapped) begin
         m_saved = addr;
         if (p != 4'd0) begin
            m_cause = expired ? 2'b11 : 2'b10;
            m_id    = lowest(p);
         end else begin
            m_cause = 2'b01;
         end
         push(TV, 1'b0);
      end
      m_budget = left;
      apply(1'($urandom), st, addr, ir, mk);
      if (trapped) noise();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit trapped;
      reset = 1'b1;
      apply(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      apply(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      chk("rst_is_priv", 8'(bus.is_priv), 8'd1);
      chk("rst_redirect", 8'(bus.redirect), 8'd0);
      chk("rst_redirect_addr", 8'(bus.redirect_addr), 8'd0);
      chk("rst_saved_addr", 8'(bus.saved_addr), 8'd0);
      chk("rst_cause", 8'(bus.cause), 8'd0);
      chk("rst_irq_id", 8'(bus.irq_id), 8'd0);
      m_saved = 4'd0; m_cause = 2'd0; m_id = 2'd0; m_budget = 0;
      reset = 1'b0;

      // Boot: two idle privileged cycles, SWAP in the third.
      priv_idle(2);
      enter_user();
      chk("user_is_priv", 8'(bus.is_priv), 8'd0);
      chk("user_redirect", 8'(bus.redirect), 8'd0);

      // Interrupt line 0 on the first user cycle.
      user_cycle(1'b0, 4'h3, 4'b0001, 4'b0001, trapped);

      // Pending irq while privileged must wait for user mode.
      apply(1'b0, 1'b1, 4'h1, 4'b1111, 4'b0010);
      apply(1'b0, 1'b0, 4'h2, 4'b1111, 4'b0010);
      chk("priv_irq_ignored", 8'(bus.is_priv), 8'd1);
      enter_user();
      user_cycle(1'b1, 4'h6, 4'b1111, 4'b0010, trapped);

      // irq=1010 masked to line 3.
      enter_user();
      user_cycle(1'b0, 4'h5, 4'b1010, 4'b1000, trapped);

      // Twenty stalled cycles, then the full budget; irq_id must keep 3.
      enter_user();
      for (int i = 0; i < 20; i++) user_cycle(1'b0, 4'($urandom), 4'($urandom), 4'd0, trapped);
      chk("stall_is_priv", 8'(bus.is_priv), 8'd0);
      chk("stall_cause", 8'(bus.cause), 8'd2);
      for (int i = 1; i <= Q; i++) user_cycle(1'b1, (i == Q) ? 4'h9 : 4'h4, 4'd0, 4'hF, trapped);
      chk("expiry_saved", 8'(bus.saved_addr), 8'h9);

      // Expiry and irq on the same edge.
      enter_user();
      for (int i = 1; i < Q; i++) user_cycle(1'b1, 4'h7, 4'b0110, 4'b0000, trapped);
      user_cycle(1'b1, 4'hA, 4'b0110, 4'b1111, trapped);

      // Reset pulsed in the middle of the return to user mode.
      priv_idle(1);
      push(m_saved, 1'b1);
      apply(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      #2;
      q.delete();
      reset = 1'b1;
      #1;
      chk("midrst_redirect", 8'(bus.redirect), 8'd0);
      chk("midrst_is_priv", 8'(bus.is_priv), 8'd1);
      chk("midrst_saved", 8'(bus.saved_addr), 8'd0);
      chk("midrst_cause", 8'(bus.cause), 8'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      m_saved = 4'd0; m_cause = 2'd0; m_id = 2'd0; m_budget = 0;
      priv_idle(3);
      chk("postrst_is_priv", 8'(bus.is_priv), 8'd1);

      // Randomized slices.
      for (int s = 0; s < 40; s++) begin
         priv_idle(int'($urandom_range(0, 3)));
         enter_user();
         for (int c = 0; c < 300; c++) begin
            logic [3:0] mk;
            mk = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'd0;
            user_cycle(1'($urandom), 4'($urandom), 4'($urandom), mk, trapped);
            if (trapped) break;
         end
      end

      priv_idle(3);
      chk("queue_drained_at_end", 8'(q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
